dense_output_layer: RTL and testbench

Fully-connected readout stage placed directly downstream of the LSTM `network` layer. It captures the hidden-state vector `outputVec` when the layer pulses `dataReady`. It computes `y = Wy·h + by` in Q6.11 fixed point using a single time-multiplexed multiply-accumulate, and presents `OUTPUT_SZ` saturated results with a one-cycle valid pulse. Weights and biases live in internal registers loaded through a simple write port.

---
 rtl/dense_output_layer.sv | 177 +++++++++++++++++
 tb/tb_dense_output_layer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_output_layer.sv
// Fully-connected readout y = W*h + b in signed fixed point, computed with one shared MAC.
// Parameters load through a write port while idle; results saturate to the word width.
module dense_output_layer #(
  parameter int unsigned HIDDEN_SZ     = 8,
  parameter int unsigned OUTPUT_SZ     = 1,
  parameter int unsigned QN            = 6,
  parameter int unsigned QM            = 11,
  parameter int unsigned BITWIDTH      = QN + QM + 1,
  parameter int unsigned ADDR_BITWIDTH = (HIDDEN_SZ * OUTPUT_SZ > 1) ?
                                         $clog2(HIDDEN_SZ * OUTPUT_SZ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [HIDDEN_SZ*BITWIDTH-1:0] hidden_vec_i,
  input  logic                          hidden_valid_i,
  output logic                          busy_o,
  input  logic                          w_en_i,
  input  logic                          w_sel_i,
  input  logic [ADDR_BITWIDTH-1:0]      w_addr_i,
  input  logic [BITWIDTH-1:0]           w_data_i,
  output logic [OUTPUT_SZ*BITWIDTH-1:0] output_vec_o,
  output logic                          output_valid_o
);

  localparam int unsigned NumW = HIDDEN_SZ * OUTPUT_SZ;
  localparam int unsigned IdxW = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
  localparam int unsigned OutW = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
  localparam int unsigned AccW = 2 * BITWIDTH + $clog2(HIDDEN_SZ) + 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(HIDDEN_SZ - 1);
  localparam logic [OutW-1:0] OutLast = OutW'(OUTPUT_SZ - 1);
  localparam logic signed [AccW-1:0] SatMax = AccW'((2 ** (BITWIDTH - 1)) - 1);
  localparam logic signed [AccW-1:0] SatMin = AccW'(-(2 ** (BITWIDTH - 1)));

  typedef enum logic [1:0] {StIdle, StMac, StStore, StDone} state_e;

  state_e                     state_q;
  logic                       busy_q;
  logic                       valid_q;
  logic [IdxW-1:0]            i_q;
  logic [OutW-1:0]            o_q;
  logic signed [AccW-1:0]     acc_q;
  logic signed [BITWIDTH-1:0] w_q   [NumW];
  logic signed [BITWIDTH-1:0] bias_q[OUTPUT_SZ];
  logic signed [BITWIDTH-1:0] h_q   [HIDDEN_SZ];
  logic signed [BITWIDTH-1:0] res_q [OUTPUT_SZ];
  logic [OUTPUT_SZ*BITWIDTH-1:0] out_q;

  logic [31:0]                  w_idx;
  logic [31:0]                  bias_idx;
  logic signed [BITWIDTH-1:0]   w_cur;
  logic signed [BITWIDTH-1:0]   h_cur;
  logic signed [BITWIDTH-1:0]   bias_sel;
  logic signed [2*BITWIDTH-1:0] w_ext;
  logic signed [2*BITWIDTH-1:0] h_ext;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [AccW-1:0]       bias_acc;
  logic signed [AccW-1:0]       acc_sh;
  logic signed [BITWIDTH-1:0]   sat_val;
  logic [OUTPUT_SZ*BITWIDTH-1:0] out_next;

  // Operand selection; the bias index points at the next row when leaving STORE.
  always_comb begin
    w_idx    = 32'(o_q) * HIDDEN_SZ + 32'(i_q);
    bias_idx = (state_q == StStore) ? 32'(o_q) + 32'd1 : 32'd0;
    w_cur    = '0;
    h_cur    = '0;
    bias_sel = '0;
    for (int unsigned j = 0; j < NumW; j++) begin
      if (w_idx == j) w_cur = w_q[j];
    end
    for (int unsigned j = 0; j < HIDDEN_SZ; j++) begin
      if (32'(i_q) == j) h_cur = h_q[j];
    end
    for (int unsigned j = 0; j < OUTPUT_SZ; j++) begin
      if (bias_idx == j) bias_sel = bias_q[j];
    end
  end

  always_comb begin
    w_ext    = {{BITWIDTH{w_cur[BITWIDTH-1]}}, w_cur};
    h_ext    = {{BITWIDTH{h_cur[BITWIDTH-1]}}, h_cur};
    prod     = w_ext * h_ext;
    bias_acc = AccW'(bias_sel) <<< QM;
    acc_sh   = acc_q >>> QM;
    if (acc_sh > SatMax) begin
      sat_val = SatMax[BITWIDTH-1:0];
    end else if (acc_sh < SatMin) begin
      sat_val = SatMin[BITWIDTH-1:0];
    end else begin
      sat_val = acc_sh[BITWIDTH-1:0];
    end
  end

  // Final STORE publishes every row at once, including the one being stored now.
  always_comb begin
    out_next = '0;
    for (int unsigned o = 0; o < OUTPUT_SZ; o++) begin
      out_next[o*BITWIDTH +: BITWIDTH] = (32'(o_q) == o) ? sat_val : res_q[o];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      i_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      for (int unsigned j = 0; j < NumW; j++) w_q[j] <= '0;
      for (int unsigned j = 0; j < HIDDEN_SZ; j++) h_q[j] <= '0;
      for (int unsigned j = 0; j < OUTPUT_SZ; j++) begin
        bias_q[j] <= '0;
        res_q[j]  <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (w_en_i) begin
            if (!w_sel_i) begin
              for (int unsigned j = 0; j < NumW; j++) begin
                if (32'(w_addr_i) == j) w_q[j] <= w_data_i;
              end
            end else begin
              for (int unsigned j = 0; j < OUTPUT_SZ; j++) begin
                if (32'(w_addr_i) == j) bias_q[j] <= w_data_i;
              end
            end
          end
          if (hidden_valid_i) begin
            for (int unsigned j = 0; j < HIDDEN_SZ; j++) begin
              h_q[j] <= hidden_vec_i[j*BITWIDTH +: BITWIDTH];
            end
            o_q     <= '0;
            i_q     <= '0;
            acc_q   <= bias_acc;
            busy_q  <= 1'b1;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_q + AccW'(prod);
          i_q   <= i_q + 1'b1;
          if (i_q == IdxLast) state_q <= StStore;
        end
        StStore: begin
          for (int unsigned o = 0; o < OUTPUT_SZ; o++) begin
            if (32'(o_q) == o) res_q[o] <= sat_val;
          end
          if (o_q == OutLast) begin
            out_q   <= out_next;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            o_q     <= o_q + 1'b1;
            i_q     <= '0;
            acc_q   <= bias_acc;
            state_q <= StMac;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign output_valid_o = valid_q;
  assign output_vec_o   = out_q;

endmodule

// File: tb/tb_dense_output_layer.sv
// Bench for dense_output_layer: directed vector table, randomized samples against an
// arithmetic reference, and hand-built sequences for busy-drop, reset abort and OUTPUT_SZ=2.
module tb_dense_output_layer;

  logic clk;
  logic rst_n;

  logic [8*18-1:0] hvec1;
  logic            hv1, busy1, wen1, wsel1, ovalid1;
  logic [2:0]      waddr1;
  logic [17:0]     wdata1, ovec1;

  logic [8*18-1:0] hvec2;
  logic            hv2, busy2, wen2, wsel2, ovalid2;
  logic [3:0]      waddr2;
  logic [17:0]     wdata2;
  logic [35:0]     ovec2;

  dense_output_layer u_dut1 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .hidden_vec_i  (hvec1),
    .hidden_valid_i(hv1),
    .busy_o        (busy1),
    .w_en_i        (wen1),
    .w_sel_i       (wsel1),
    .w_addr_i      (waddr1),
    .w_data_i      (wdata1),
    .output_vec_o  (ovec1),
    .output_valid_o(ovalid1)
  );

  dense_output_layer #(.OUTPUT_SZ(2)) u_dut2 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .hidden_vec_i  (hvec2),
    .hidden_valid_i(hv2),
    .busy_o        (busy2),
    .w_en_i        (wen2),
    .w_sel_i       (wsel2),
    .w_addr_i      (waddr2),
    .w_data_i      (wdata2),
    .output_vec_o  (ovec2),
    .output_valid_o(ovalid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the parameters should hold and the sample presented.
  int mw[8];
  int mb;
  int hcur[8];

  typedef struct {
    string       name;
    int          w0;
    int          wr;
    int          h0;
    int          hr;
    int          b;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ref1();
    longint acc;
    acc = longint'(mb) * 2048;
    for (int i = 0; i < 8; i++) acc += longint'(mw[i]) * longint'(hcur[i]);
    acc = acc >>> 11;
    if (acc > 131071) return 18'h1FFFF;
    if (acc < -131072) return 18'h20000;
    return 18'(acc);
  endfunction

  task automatic wr1(input logic sel, input int addr, input int val);
    wen1   = 1'b1;
    wsel1  = sel;
    waddr1 = 3'(addr);
    wdata1 = 18'(val);
    @(posedge clk);
    #1 wen1 = 1'b0;
    if (!sel && addr < 8) mw[addr] = val;
    else if (sel && addr < 1) mb = val;
  endtask

  task automatic load1(input int w0, input int wr, input int b);
    wr1(1'b0, 0, w0);
    for (int a = 1; a < 8; a++) wr1(1'b0, a, wr);
    wr1(1'b1, 0, b);
  endtask

  // Launch hcur, return first-valid latency, its value and the number of valid pulses.
  task automatic run1(output int lat, output logic [17:0] y, output int np);
    for (int i = 0; i < 8; i++) hvec1[i*18 +: 18] = 18'(hcur[i]);
    hv1 = 1'b1;
    @(posedge clk);
    #1;
    hv1  = 1'b0;
    wen1 = 1'b0;
    lat  = -1;
    np   = 0;
    y    = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_rise", {63'd0, busy1}, 64'd1);
      if (ovalid1) begin
        np++;
        if (lat < 0) begin
          lat = k;
          y   = ovec1;
        end
      end
      if (lat > 0 && k == lat + 1) check("busy_fall", {63'd0, busy1}, 64'd0);
    end
    if (lat < 0) check("valid_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, np, lat2;
    logic [17:0] y;
    logic [35:0] y2;

    tbl[0] = '{"basic_sum",  2048,   2048,   1024,  1024,  0,   18'd8192};
    tbl[1] = '{"neg_bias",   -2048,  -2048,  1024,  1024,  512, 18'h3E200};
    tbl[2] = '{"sat_pos",    63488,  63488,  63488, 63488, 0,   18'h1FFFF};
    tbl[3] = '{"sat_neg",    -63488, -63488, 63488, 63488, 0,   18'h20000};
    tbl[4] = '{"floor_lsb",  -1,     0,      1,     0,     0,   18'h3FFFF};

    rst_n = 1'b0;
    {hv1, wen1, wsel1, hv2, wen2, wsel2} = '0;
    hvec1 = '0; waddr1 = '0; wdata1 = '0;
    hvec2 = '0; waddr2 = '0; wdata2 = '0;
    for (int i = 0; i < 8; i++) mw[i] = 0;
    mb = 0;
    #12;
    check("rst_busy",  {63'd0, busy1},   64'd0);
    check("rst_valid", {63'd0, ovalid1}, 64'd0);
    check("rst_out",   {46'd0, ovec1},   64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      load1(tbl[t].w0, tbl[t].wr, tbl[t].b);
      hcur[0] = tbl[t].h0;
      for (int i = 1; i < 8; i++) hcur[i] = tbl[t].hr;
      run1(lat, y, np);
      check({tbl[t].name, "_val"}, {46'd0, y}, {46'd0, tbl[t].exp});
      check({tbl[t].name, "_lat"}, 64'(lat), 64'd10);
      check({tbl[t].name, "_pulses"}, 64'(np), 64'd1);
    end
    check("out_hold", {46'd0, ovec1}, {46'd0, tbl[4].exp});

    // Randomized samples: alternate full-range and small-magnitude operands.
    for (int r = 0; r < 20; r++) begin
      int span;
      span = (r % 2 == 0) ? 131072 : 4096;
      for (int a = 0; a < 8; a++) wr1(1'b0, a, int'($urandom_range(0, 2 * span - 1)) - span);
      wr1(1'b1, 0, int'($urandom_range(0, 2 * span - 1)) - span);
      for (int i = 0; i < 8; i++) hcur[i] = int'($urandom_range(0, 2 * span - 1)) - span;
      run1(lat, y, np);
      check("rand_val", {46'd0, y}, {46'd0, ref1()});
    end

    // Out-of-range bias address must not disturb bias[0].
    load1(2048, 2048, 0);
    wr1(1'b1, 3, 2048);
    for (int i = 0; i < 8; i++) hcur[i] = 1024;
    run1(lat, y, np);
    check("oob_bias", {46'd0, y}, {46'd0, ref1()});

    // Bias write in the capture cycle: this sample uses the old bias, the next the new one.
    wen1 = 1'b1; wsel1 = 1'b1; waddr1 = 3'd0; wdata1 = 18'd512;
    run1(lat, y, np);
    check("same_cycle_old", {46'd0, y}, 64'd8192);
    mb = 512;
    run1(lat, y, np);
    check("same_cycle_new", {46'd0, y}, {46'd0, ref1()});

    // Busy drop: second strobe and a weight write while busy are both ignored.
    wr1(1'b1, 0, 0);
    for (int i = 0; i < 8; i++) hvec1[i*18 +: 18] = 18'd1024;
    hv1 = 1'b1;
    @(posedge clk);
    #1 hv1 = 1'b0;
    np  = 0;
    y   = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ovalid1) begin
        np++;
        y = ovec1;
      end
      if (k == 3) begin
        for (int i = 0; i < 8; i++) hvec1[i*18 +: 18] = 18'd2048;
        hv1 = 1'b1;
        wen1 = 1'b1; wsel1 = 1'b0; waddr1 = 3'd0; wdata1 = 18'd0;
      end
      if (k == 4) begin
        hv1  = 1'b0;
        wen1 = 1'b0;
      end
    end
    check("drop_pulses", 64'(np), 64'd1);
    check("drop_val", {46'd0, y}, 64'd8192);
    @(posedge clk);
    #1;
    run1(lat, y, np);
    check("busy_write_ignored", {46'd0, y}, 64'd8192);

    // Reset four cycles into MAC aborts and clears everything.
    for (int i = 0; i < 8; i++) hvec1[i*18 +: 18] = 18'd1024;
    hv1 = 1'b1;
    @(posedge clk);
    #1 hv1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy",  {63'd0, busy1},   64'd0);
    check("abort_valid", {63'd0, ovalid1}, 64'd0);
    check("abort_out",   {46'd0, ovec1},   64'd0);
    for (int i = 0; i < 8; i++) mw[i] = 0;
    mb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run1(lat, y, np);
    check("post_reset_val", {46'd0, y}, 64'd0);
    check("post_reset_lat", 64'(lat), 64'd10);
    check("post_reset_pulses", 64'(np), 64'd1);

    // Two-output instance.
    for (int a = 0; a < 16; a++) begin
      wen2 = 1'b1; wsel2 = 1'b0; waddr2 = 4'(a);
      wdata2 = (a < 8) ? 18'(2048) : 18'(-2048);
      @(posedge clk);
      #1;
    end
    wsel2 = 1'b1; waddr2 = 4'd0; wdata2 = 18'd0;
    @(posedge clk);
    #1 waddr2 = 4'd1; wdata2 = 18'd2048;
    @(posedge clk);
    #1 wen2 = 1'b0;
    for (int i = 0; i < 8; i++) hvec2[i*18 +: 18] = 18'd2048;
    hv2 = 1'b1;
    @(posedge clk);
    #1 hv2 = 1'b0;
    lat2 = -1;
    y2   = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ovalid2 && lat2 < 0) begin
        lat2 = k;
        y2   = ovec2;
      end
    end
    check("o2_lat", 64'(lat2), 64'd19);
    check("o2_y0", {46'd0, y2[17:0]},  64'd16384);
    check("o2_y1", {46'd0, y2[35:18]}, 64'h3C800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
